spi_txn_arbiter: RTL and testbench

- Shares the single SPI master (start / rd_wr / address / out_data in, in_data out) between NUM_REQ independent requesters.
- Performs round-robin arbitration and latches the winner's command.
- Sequences the master's fixed-length frame by driving start for a counted window, then returns read data and a done pulse to the winner.
- Sits between client logic and the SPI top, on the master clock domain.

---
 rtl/spi_arb_pkg.sv | 27 ++
 rtl/spi_rr_arbiter.sv | 47 ++++
 rtl/spi_txn_arbiter.sv | 170 +++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// ---------------------------------------------------------------------------
// spi_arb_pkg
// Shared types and constants for the SPI transaction arbiter.
//   state_t    : arbiter FSM states (IDLE, XFER, GAP, DONE)
//   spi_cmd_t  : one requester's command (direction, slave address, write data)
//   ADDR_W     : SPI slave address width
//   DATA_W     : SPI data byte width
// ---------------------------------------------------------------------------
package spi_arb_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic              rd_wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } spi_cmd_t;

endpackage

// File: rtl/spi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// spi_rr_arbiter
// Combinational round-robin search: picks the first asserted request at or
// above the pointer, wrapping past the top requester back to 0.
// Ports:
//   req      in  NUM_REQ  request vector
//   ptr      in  IDX_W    highest-priority requester index for this search
//   gnt_oh   out NUM_REQ  one-hot winner (all zero when nothing requests)
//   gnt_idx  out IDX_W    binary index of the winner
//   gnt_vld  out 1        at least one request is asserted
// The pointer register itself lives in the parent.
// ---------------------------------------------------------------------------
module spi_rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    always_comb begin
        int               k;
        logic [IDX_W-1:0] kk;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        k       = 0;
        kk      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Candidate i steps away from the pointer, folded back into range.
            k = int'(ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            kk = IDX_W'(k);
            if (!gnt_vld && req[kk]) begin
                gnt_vld    = 1'b1;
                gnt_oh[kk] = 1'b1;
                gnt_idx    = kk;
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// ---------------------------------------------------------------------------
// spi_txn_arbiter
// Shares one SPI master between NUM_REQ requesters. Round-robin picks a
// winner in IDLE; its command is latched onto the master_* outputs, start is
// held for TXN_CYCLES, then start stays low for GAP_CYCLES before the read
// byte is captured and a one-cycle done pulse goes back to the winner.
// Ports:
//   mclk             in   master clock
//   reset            in   asynchronous active-low reset
//   req_i            in   per-requester request level
//   rd_wr_i          in   per-requester direction (1 = read)
//   addr_i           in   packed 7-bit addresses, requester k at [7k+6:7k]
//   wdata_i          in   packed write bytes, requester k at [8k+7:8k]
//   gnt_o            out  one-hot grant during XFER and GAP
//   done_o           out  one-cycle completion pulse to the winner
//   rdata_o          out  read byte (0 after a write), held until next DONE
//   busy_o           out  FSM not in IDLE
//   start            out  SPI master start
//   master_rd_wr     out  SPI master direction
//   master_address   out  SPI master slave address
//   master_out_data  out  SPI master write byte
//   master_in_data   in   SPI master read byte
// ---------------------------------------------------------------------------
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int TXN_CYCLES = 20,
    parameter int GAP_CYCLES = 2
) (
    input  logic                      mclk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        rd_wr_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      busy_o,
    output logic                      start,
    output logic                      master_rd_wr,
    output logic [ADDR_W-1:0]         master_address,
    output logic [DATA_W-1:0]         master_out_data,
    input  logic [DATA_W-1:0]         master_in_data
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (TXN_CYCLES > GAP_CYCLES) ? TXN_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     win_idx_q;
    logic [NUM_REQ-1:0]   win_oh_q;
    spi_cmd_t             cmd_q;
    spi_cmd_t             cmd_sel;
    logic [DATA_W-1:0]    rdata_q;

    logic [NUM_REQ-1:0]   arb_oh;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_vld;

    logic                 latch_cmd;

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (req_i),
        .ptr     (ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Current winner's command, picked out of the packed request buses.
    always_comb begin
        cmd_sel.rd_wr = rd_wr_i[arb_idx];
        cmd_sel.addr  = addr_i[int'(arb_idx)*ADDR_W +: ADDR_W];
        cmd_sel.wdata = wdata_i[int'(arb_idx)*DATA_W +: DATA_W];
    end

    assign latch_cmd = (state_q == IDLE) && arb_vld;

    // State register
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d = XFER;
                    cnt_d   = CNT_W'(TXN_CYCLES - 1);
                end
            end
            XFER: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        start   = (state_q == XFER);
        busy_o  = (state_q != IDLE);
        gnt_o   = ((state_q == XFER) || (state_q == GAP)) ? win_oh_q : '0;
        done_o  = (state_q == DONE) ? win_oh_q : '0;
    end

    // Command latch, winner bookkeeping, read capture and rr pointer.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            cmd_q     <= '0;
            win_idx_q <= '0;
            win_oh_q  <= '0;
            rdata_q   <= '0;
            ptr_q     <= '0;
        end else begin
            if (latch_cmd) begin
                cmd_q     <= cmd_sel;
                win_idx_q <= arb_idx;
                win_oh_q  <= arb_oh;
            end
            // Read byte is sampled on the last GAP cycle so it is stable in DONE.
            if ((state_q == GAP) && (cnt_q == '0)) begin
                rdata_q <= cmd_q.rd_wr ? master_in_data : '0;
            end
            if (state_q == DONE) begin
                ptr_q <= (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + 1'b1;
            end
        end
    end

    assign master_rd_wr    = cmd_q.rd_wr;
    assign master_address  = cmd_q.addr;
    assign master_out_data = cmd_q.wdata;
    assign rdata_o         = rdata_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
module tb_spi_txn_arbiter;

    localparam int N = 4;

    logic           mclk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_i;
    logic [N-1:0]   rd_wr_i;
    logic [N*7-1:0] addr_i;
    logic [N*8-1:0] wdata_i;
    logic [N-1:0]   gnt_o;
    logic [N-1:0]   done_o;
    logic [7:0]     rdata_o;
    logic           busy_o;
    logic           start;
    logic           master_rd_wr;
    logic [6:0]     master_address;
    logic [7:0]     master_out_data;
    logic [7:0]     master_in_data;

    spi_txn_arbiter #(
        .NUM_REQ    (N),
        .TXN_CYCLES (20),
        .GAP_CYCLES (2)
    ) dut (
        .mclk            (mclk),
        .reset           (reset),
        .req_i           (req_i),
        .rd_wr_i         (rd_wr_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .gnt_o           (gnt_o),
        .done_o          (done_o),
        .rdata_o         (rdata_o),
        .busy_o          (busy_o),
        .start           (start),
        .master_rd_wr    (master_rd_wr),
        .master_address  (master_address),
        .master_out_data (master_out_data),
        .master_in_data  (master_in_data)
    );

    always #5 mclk = ~mclk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [N-1:0] req;
        logic         rd;
        logic [6:0]   addr;
        logic [7:0]   wd;
        logic [7:0]   in;
        int           win;
        logic [7:0]   exp_rdata;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Winner slot gets the vector's command; other slots get distinct filler.
    task automatic set_slots(input vec_t v);
        for (int k = 0; k < N; k++) begin
            if (k == v.win) begin
                rd_wr_i[k]         = v.rd;
                addr_i[7*k +: 7]   = v.addr;
                wdata_i[8*k +: 8]  = v.wd;
            end else begin
                rd_wr_i[k]         = ~v.rd;
                addr_i[7*k +: 7]   = 7'(7'h70 + k);
                wdata_i[8*k +: 8]  = 8'(8'hE0 + k);
            end
        end
        master_in_data = v.in;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
    task automatic do_txn(input vec_t v, input string tag);
        int cyc;
        int nstart;
        bit seen;
        set_slots(v);
        req_i  = v.req;
        cyc    = 0;
        nstart = 0;
        seen   = 0;
        while (cyc < 60) begin
            @(negedge mclk);
            cyc++;
            if (start) begin
                nstart++;
                if (!seen) begin
                    seen = 1;
                    chk({tag, " start_latency"}, 32'(cyc), 32'd1);
                    chk({tag, " master_address"}, 32'(master_address), 32'(v.addr));
                    chk({tag, " master_rd_wr"}, 32'(master_rd_wr), 32'(v.rd));
                    chk({tag, " master_out_data"}, 32'(master_out_data), 32'(v.wd));
                    chk({tag, " gnt_o"}, 32'(gnt_o), 32'(1) << v.win);
                    chk({tag, " busy_o"}, 32'(busy_o), 32'd1);
                    req_i = '0;
                end
            end
            if (done_o != '0) break;
        end
        chk({tag, " done_o"}, 32'(done_o), 32'(1) << v.win);
        chk({tag, " done_latency"}, 32'(cyc), 32'd23);
        chk({tag, " start_cycles"}, 32'(nstart), 32'd20);
        chk({tag, " rdata_o"}, 32'(rdata_o), 32'(v.exp_rdata));
        chk({tag, " gnt_in_done"}, 32'(gnt_o), 32'd0);
        chk({tag, " addr_hold"}, 32'(master_address), 32'(v.addr));
        @(negedge mclk);
        chk({tag, " done_pulse_end"}, 32'(done_o), 32'd0);
        chk({tag, " rdata_hold"}, 32'(rdata_o), 32'(v.exp_rdata));
        chk({tag, " busy_idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[5];
        int nfr;
        int low;
        int cyc;
        bit prev;
        bit seen;
        bit any_done;
        vec_t v;

        //            req      rd    addr   wd     in     win  exp_rdata
        tbl[0] = '{4'b0001, 1'b0, 7'h15, 8'hA5, 8'h00, 0, 8'h00};
        tbl[1] = '{4'b0100, 1'b1, 7'h40, 8'h00, 8'h3C, 2, 8'h3C};
        tbl[2] = '{4'b0101, 1'b0, 7'h2A, 8'h5A, 8'h99, 0, 8'h00};
        tbl[3] = '{4'b0101, 1'b1, 7'h01, 8'h11, 8'hC3, 2, 8'hC3};
        tbl[4] = '{4'b1000, 1'b1, 7'h7F, 8'h22, 8'hFF, 3, 8'hFF};
        tbl[5] = '{4'b0110, 1'b0, 7'h00, 8'h00, 8'h77, 1, 8'h00};
        tbl[6] = '{4'b1111, 1'b1, 7'h33, 8'h44, 8'h81, 2, 8'h81};

        reset          = 1'b0;
        req_i          = '0;
        rd_wr_i        = '0;
        addr_i         = '0;
        wdata_i        = '0;
        master_in_data = 8'h5E;

        // Reset state
        repeat (2) @(negedge mclk);
        chk("rst start", 32'(start), 32'd0);
        chk("rst busy_o", 32'(busy_o), 32'd0);
        chk("rst gnt_o", 32'(gnt_o), 32'd0);
        chk("rst done_o", 32'(done_o), 32'd0);
        chk("rst rdata_o", 32'(rdata_o), 32'd0);
        chk("rst master", {16'd0, master_rd_wr, master_address, master_out_data}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge mclk);
        chk("idle_no_req busy_o", 32'(busy_o), 32'd0);
        chk("idle_no_req start", 32'(start), 32'd0);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            do_txn(tbl[i], $sformatf("vec%0d", i));
        end

        // Late change of address and early drop of request while granted
        v = '{4'b0010, 1'b0, 7'h11, 8'h77, 8'h00, 1, 8'h00};
        set_slots(v);
        req_i = 4'b0010;
        cyc   = 0;
        seen  = 0;
        while (cyc < 60) begin
            @(negedge mclk);
            cyc++;
            if (start && !seen) begin
                seen = 1;
                addr_i[7 +: 7] = 7'h22;
                wdata_i[8 +: 8] = 8'h99;
                req_i = '0;
            end
            if (done_o != '0) break;
        end
        chk("late done_o", 32'(done_o), 32'b0010);
        chk("late master_address", 32'(master_address), 32'h11);
        chk("late master_out_data", 32'(master_out_data), 32'h77);
        @(negedge mclk);

        // Contention from reset: all four requesters held high
        order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < N; k++) begin
            addr_i[7*k +: 7]  = 7'(7'h50 + k);
            wdata_i[8*k +: 8] = 8'(8'hB0 + k);
        end
        rd_wr_i = '0;
        reset = 1'b0;
        repeat (2) @(negedge mclk);
        req_i = 4'b1111;
        reset = 1'b1;
        nfr  = 0;
        low  = 0;
        prev = 0;
        cyc  = 0;
        while (cyc < 400) begin
            @(negedge mclk);
            cyc++;
            if (start && !prev && nfr < 5) begin
                if (nfr > 0) chk($sformatf("cont gap_low%0d_ge3", nfr), 32'(low >= 3), 32'd1);
                chk($sformatf("cont gnt%0d", nfr), 32'(gnt_o), 32'(1) << order[nfr]);
                chk($sformatf("cont addr%0d", nfr), 32'(master_address), 32'(7'h50 + order[nfr]));
                nfr++;
                if (nfr == 5) req_i = '0;
            end
            if (start) low = 0;
            else low++;
            prev = start;
            if (nfr == 5 && !busy_o) break;
        end
        chk("cont frames", 32'(nfr), 32'd5);

        // Reset in the middle of XFER
        v = '{4'b0100, 1'b1, 7'h6B, 8'h00, 8'hAA, 2, 8'hAA};
        set_slots(v);
        req_i = 4'b0100;
        cyc = 0;
        while (cyc < 60 && !start) begin
            @(negedge mclk);
            cyc++;
        end
        chk("midrst start_seen", 32'(start), 32'd1);
        repeat (10) @(negedge mclk);
        chk("midrst in_xfer", 32'(start), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midrst start", 32'(start), 32'd0);
        chk("midrst gnt_o", 32'(gnt_o), 32'd0);
        chk("midrst busy_o", 32'(busy_o), 32'd0);
        req_i = '0;
        any_done = 0;
        repeat (3) begin
            @(negedge mclk);
            if (done_o != '0) any_done = 1;
        end
        chk("midrst no_done", 32'(any_done), 32'd0);
        reset = 1'b1;
        // Pointer must be back at 0: requester 0 beats 3
        do_txn('{4'b1001, 1'b1, 7'h5C, 8'h00, 8'h96, 0, 8'h96}, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
